// File: rtl/div_unit.sv
// Sequential unsigned restoring divider: one quotient bit every two cycles
// (shift, then trial subtract), with a one-cycle done pulse on completion.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV0, DIV1} state_t;

    state_t           state;
    logic             prev_go;
    logic             armed;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic             launch;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // R keeps one extra bit so the shifted partial remainder cannot overflow
    // when the divisor exceeds 2^(WIDTH-1); the stored remainder always fits WIDTH.
    always_comb begin
        launch = go & ~prev_go & armed & (state == IDLE);
        diff   = r - {1'b0, d};
        r_next = r;
        q_next = q;
        if (!diff[WIDTH]) begin
            r_next = diff;
            q_next = {q[WIDTH-1:1], 1'b1};
        end
    end

    // armed blocks a launch from a go that was already high when reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_go     <= 1'b0;
            armed       <= 1'b0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done    <= 1'b0;
            prev_go <= go;
            armed   <= armed | ~go;
            case (state)
                IDLE: begin
                    if (launch) begin
                        if (divisor != '0) begin
                            r           <= '0;
                            q           <= dividend;
                            d           <= divisor;
                            count       <= CW'(WIDTH);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= DIV0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                DIV0: begin
                    {r, q} <= {r[WIDTH-1:0], q, 1'b0};
                    state  <= DIV1;
                end
                DIV1: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= DIV0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes expected results computed
// with plain / and %, and a monitor pops and compares on every done pulse.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] n, d, q, r;
        bit           dbz;
        longint       lat;
        longint       launch;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [W-1:0] n, input logic [W-1:0] d, input longint launch);
        exp_t e;
        e.n = n;
        e.d = d;
        e.launch = launch;
        if (d == 0) begin
            e.q = '1; e.r = n; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.q = n / d; e.r = n % d; e.dbz = 1'b0; e.lat = 2 * W;
        end
        sb.push_back(e);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {32'b0, quotient}, {32'b0, e.q});
                chk("remainder", {32'b0, remainder}, {32'b0, e.r});
                chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
                chk("latency", 64'(cyc - e.launch), 64'(e.lat));
                if (!e.dbz) begin
                    chk("invariant", {32'b0, quotient} * {32'b0, e.d} + {32'b0, remainder}, {32'b0, e.n});
                    chk("rem_lt_div", {63'b0, (remainder < e.d)}, 64'd1);
                end
            end
        end
    end

    task automatic wait_done(output int bc);
        bc = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy) bc++;
            if (!busy && sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("timeout_outstanding", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d);
        int bc;
        @(negedge clk);
        dividend = n;
        divisor  = d;
        go       = 1'b1;
        push(n, d, cyc + 1);
        @(negedge clk);
        go = 1'b0;
        wait_done(bc);
        chk("busy_cycles", 64'(bc), (d != 0) ? 64'(2 * W) : 64'd0);
    endtask

    initial begin
        int bc;
        logic [W-1:0] n, d;

        #1;
        chk("rst_quotient", {32'b0, quotient}, 64'd0);
        chk("rst_remainder", {32'b0, remainder}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(32'd100, 32'd7);
        run_op(32'd5, 32'd9);
        run_op(32'hFFFF_FFFF, 32'd1);
        run_op(32'h0000_1234, 32'd0);
        run_op(32'hFFFF_FFFF, 32'h8000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd0, 32'd3);

        // go held high for 300 cycles launches exactly once
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd33; go = 1'b1;
        push(32'd1000, 32'd33, cyc + 1);
        repeat (300) @(negedge clk);
        go = 1'b0;
        wait_done(bc);
        chk("held_go_busy", {63'b0, busy}, 64'd0);

        // go toggled during an operation is ignored
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; go = 1'b1;
        push(32'd1000, 32'd3, cyc + 1);
        @(negedge clk); go = 1'b0;
        repeat (10) @(negedge clk); go = 1'b1;
        repeat (3) @(negedge clk); go = 1'b0;
        wait_done(bc);
        repeat (5) @(negedge clk);
        chk("toggle_busy_after", {63'b0, busy}, 64'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; go = 1'b1;
        push(32'd100, 32'd7, cyc + 1);
        @(negedge clk); go = 1'b0;
        repeat (19) @(negedge clk);
        chk("midop_busy", {63'b0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_quotient", {32'b0, quotient}, 64'd0);
        chk("abort_remainder", {32'b0, remainder}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_dbz", {63'b0, div_by_zero}, 64'd0);
        go = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_through_reset_busy", {63'b0, busy}, 64'd0);
        go = 1'b0;
        repeat (2) @(negedge clk);
        run_op(32'd81, 32'd9);

        for (int i = 0; i < 900; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            n = $urandom;
            if (sel == 0) d = '0;
            else if (sel < 4) d = $urandom_range(1, 255);
            else d = $urandom;
            if (sel == 9) n = $urandom_range(0, 1000);
            run_op(n, d);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
